// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB prescaled down-counter timer with sticky expiry flag and level interrupt
module apb_timer_slave #(
    parameter int SEL_BIT = 0,
    parameter int CNT_W   = 32
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Irq
);
    logic en, auto_rl, ie, exp_f;
    logic [7:0] presc, pcnt;
    logic [CNT_W-1:0] load, count;
    logic sel, wr, wr_ctrl, wr_load, wr_stat, tick, expire;
    logic [31:0] rmux;
    logic unused_ok;
    assign unused_ok = &{1'b0, Paddr, Pwdata, Pselx};
    assign sel     = Pselx[SEL_BIT];
    assign wr      = sel & Penable & Pwrite;
    assign wr_ctrl = wr & (Paddr[7:2] == 6'd0);
    assign wr_load = wr & (Paddr[7:2] == 6'd1);
    assign wr_stat = wr & (Paddr[7:2] == 6'd3);
    assign tick    = en & (pcnt == presc);
    // a LOAD write landing on a tick supersedes that tick's expiry
    assign expire  = tick & (count == '0) & ~wr_load;
    assign Irq     = exp_f & ie;
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
            presc   <= '0;
            load    <= '0;
            count   <= '0;
            pcnt    <= '0;
            exp_f   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en      <= Pwdata[0];
                auto_rl <= Pwdata[1];
                ie      <= Pwdata[2];
                presc   <= Pwdata[15:8];
            end else if (expire & ~auto_rl) begin
                en <= 1'b0;
            end
            if (wr_load)
                load <= Pwdata[CNT_W-1:0];
            count <= wr_load ? Pwdata[CNT_W-1:0] :
                     !tick ? count :
                     (count != '0) ? count - CNT_W'(1) :
                     auto_rl ? load : count;
            pcnt  <= (wr_load | (wr_ctrl & Pwdata[0] & ~en)) ? '0 :
                     !en ? pcnt :
                     tick ? '0 : pcnt + 8'd1;
            // expiry set wins over a same-edge W1C
            exp_f <= expire | (exp_f & ~(wr_stat & Pwdata[0]));
        end
    end
    always_comb begin
        rmux = '0;
        case (Paddr[7:2])
            6'd0:    rmux = {16'd0, presc, 5'd0, ie, auto_rl, en};
            6'd1:    rmux = 32'(load);
            6'd2:    rmux = 32'(count);
            6'd3:    rmux = {31'd0, exp_f};
            default: rmux = '0;
        endcase
    end
    assign Prdata = (sel & ~Pwrite) ? rmux : '0;
endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: scoreboard bench for apb_timer_slave against a cycle-level reference model
module tb_apb_timer_slave;
    logic        Hclk = 1'b0;
    logic        Hreset = 1'b1;
    logic [2:0]  Pselx;
    logic        Penable, Pwrite;
    logic [31:0] Paddr, Pwdata, Prdata;
    logic        Irq;

    apb_timer_slave #(.SEL_BIT(0), .CNT_W(32)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .Irq(Irq)
    );

    always #5 Hclk = ~Hclk;

    int tests = 0;
    int fails = 0;
    logic [31:0] rdq[$];

    // reference model state, named after the register map fields
    bit          m_en, m_auto, m_ie, m_exp;
    logic [7:0]  m_presc, m_pcnt;
    logic [31:0] m_load, m_count;

    always @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
            m_presc = 0; m_pcnt = 0; m_load = 0; m_count = 0;
        end else begin
            bit w, wc, wl, ws, tk, ex;
            w  = Pselx[0] && Penable && Pwrite;
            wc = w && Paddr[7:0] == 8'h00;
            wl = w && Paddr[7:0] == 8'h04;
            ws = w && Paddr[7:0] == 8'h0C && Pwdata[0];
            tk = m_en && m_pcnt == m_presc;
            ex = tk && m_count == 0 && !wl;
            if (wl || (wc && Pwdata[0] && !m_en)) m_pcnt = 0;
            else if (tk) m_pcnt = 0;
            else if (m_en) m_pcnt = m_pcnt + 1;
            if (wl) m_count = Pwdata;
            else if (tk) m_count = (m_count != 0) ? m_count - 1 : (m_auto ? m_load : 0);
            if (ex) m_exp = 1;
            else if (ws) m_exp = 0;
            if (wl) m_load = Pwdata;
            if (wc) begin
                m_en = Pwdata[0]; m_auto = Pwdata[1]; m_ie = Pwdata[2]; m_presc = Pwdata[15:8];
            end else if (ex && !m_auto) m_en = 0;
        end
    end

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        case (a[7:0])
            8'h00:   return {16'h0, m_presc, 5'h0, m_ie, m_auto, m_en};
            8'h04:   return m_load;
            8'h08:   return m_count;
            8'h0C:   return {31'h0, m_exp};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", n, $time, act, req);
        end
    endtask

    // monitor: pops an expectation whenever the slave is presenting read data
    always @(negedge Hclk) begin
        if (!Hreset) begin
            if (Pselx[0] && !Pwrite) begin
                if (rdq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rdq at %0t: read presented with no expected value", $time);
                end else chk($sformatf("prdata@%h", Paddr), Prdata, rdq.pop_front());
            end else chk("prdata_idle", Prdata, 32'h0);
            chk("irq", 32'(Irq), 32'(m_exp & m_ie));
        end
    end

    task automatic cyc(input logic [2:0] s, input bit en, input bit w, input logic [31:0] a, input logic [31:0] d);
        @(posedge Hclk);
        #1;
        Pselx = s; Penable = en; Pwrite = w; Paddr = a; Pwdata = d;
        if (s[0] && !w) rdq.push_back(model_rd(a));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s = 3'b001);
        cyc(s, 0, 1, a, d);
        cyc(s, 1, 1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(3'b001, 0, 0, a, 0);
        cyc(3'b001, 1, 0, a, 0);
    endtask

    task automatic peek(input logic [31:0] a, input int n);
        repeat (n) cyc(3'b001, 0, 0, a, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(3'b000, 0, 0, 0, 0);
    endtask

    initial begin
        Pselx = 0; Penable = 0; Pwrite = 0; Paddr = 0; Pwdata = 0;
        repeat (2) @(posedge Hclk);
        #1 Hreset = 0;
        rd(0); rd(4); rd(8); rd(12);
        // one-shot countdown from 3 with interrupt enabled
        wr(4, 3); wr(0, 32'h5); peek(8, 6); rd(12); rd(0);
        wr(12, 1); rd(12); idle(2);
        // auto-reload with prescale 1
        wr(4, 2); wr(0, 32'h103); peek(8, 14); peek(12, 6);
        // W1C racing a period-3 expiry
        wr(4, 2); wr(0, 32'h7);
        repeat (8) begin wr(12, 1); rd(12); end
        // decode
        wr(0, 0); wr(4, 32'h55); wr(4, 32'hDEAD, 3'b010); rd(4);
        wr(32'h10, 32'hFFFF); rd(32'h10); wr(8, 32'h77); rd(8);
        // read path
        wr(4, 32'h1234); rd(4); idle(2);
        // reset in the middle of a running count
        wr(4, 5); wr(0, 32'h7); idle(20);
        @(negedge Hclk);
        #2 Hreset = 1;
        @(posedge Hclk);
        #1 Hreset = 0;
        rd(0); rd(4); rd(8); rd(12); peek(8, 4);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, d;
            logic [2:0] s;
            int k;
            k = $urandom_range(0, 4);
            a = (k == 4) ? 32'h10 : 32'(k * 4);
            d = $urandom;
            if (a == 0) d = {d[31:16], 8'($urandom_range(0, 3)), d[7:0]};
            if (a == 4 && $urandom_range(0, 7) != 0) d = $urandom_range(0, 6);
            k = $urandom_range(0, 5);
            s = (k == 0) ? 3'b010 : (k == 1) ? 3'b101 : 3'b001;
            case ($urandom_range(0, 5))
                0, 1, 2: wr(a, d, s);
                3, 4:    rd(a);
                default: cyc(s, 0, 1, a, d);
            endcase
            idle($urandom_range(0, 2));
        end
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB timer peripheral on the downstream side of the AHB-to-APB bridge, alongside the APB interface model. It is selected by one bit of the bridge's `Pselx` bus and decodes the bridge's APB setup/access phases into a four-register bank. The bank drives a prescaled down-counter with one-shot and auto-reload modes, a sticky expiry flag and a level interrupt. Read data returns on `Prdata` with no wait states, because the bridge has no `Pready` input.

## Interface
- `SEL_BIT`, default 0: index of the `Pselx` bit that selects this slave (0..2).
- `CNT_W`, default 32: width of the LOAD and COUNT registers (1..32); narrower values zero-extend on read.
- `Hclk` input, 1 bit: single clock; all state updates on its rising edge.
- `Hreset` input, 1 bit: asynchronous, active-high reset.
- `Pselx` input, 3 bits: APB slave selects from the bridge; only `Pselx[SEL_BIT]` is used.
- `Penable` input, 1 bit: APB access phase.
- `Pwrite` input, 1 bit: 1 = write, 0 = read.
- `Paddr` input, 32 bits: byte address; only `Paddr[7:2]` is decoded.
- `Pwdata` input, 32 bits: write data.
- `Prdata` output, 32 bits: read data.
- `Irq` output, 1 bit: level interrupt.

## Operation
- Definitions:
  - `sel = Pselx[SEL_BIT]`.
  - Write strobe `wr = sel & Penable & Pwrite`, which takes effect on the rising edge of `Hclk`.
- Register map (offset = `Paddr[7:0]`):
  - 0x00 CTRL, R/W: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable), bits[15:8] PRESC; all other bits read 0.
  - 0x04 LOAD, R/W: reload value, `CNT_W` bits.
  - 0x08 COUNT, RO: current count. Writes are ignored.
  - 0x0C STATUS: bit0 EXP, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
  - Any other offset reads 0 and ignores writes.
- Read path:
  - `Prdata` is combinational: it is the selected register when `sel & ~Pwrite`, in both setup and access phases.
  - Otherwise `Prdata` = 0.
  - Reads have no side effects.
- Write side effects:
  - A write to LOAD also sets COUNT to the new value and clears the prescaler.
  - A CTRL write that changes EN from 0 to 1 clears the prescaler.
- Prescaler:
  - 8-bit counter `pcnt`, active only while EN = 1.
  - `tick` is asserted when `pcnt == PRESC`; `pcnt` then wraps to 0, otherwise it increments.
  - With PRESC = 0, `tick` is asserted every cycle.
- Counter, on `tick`:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0 (expiry): EXP is set to 1.
    - AUTO = 1: COUNT is reloaded from LOAD.
    - AUTO = 0: EN is cleared and COUNT stays 0.
- Auto-reload period = (LOAD+1)·(PRESC+1) cycles between EXP-set events.
- `Irq = EXP & IE`, decoded directly from flops (no added latency).
- Simultaneous events:
  - Expiry and a STATUS W1C on the same edge: the set wins, so EXP = 1.
  - One-shot auto-clear of EN and a CTRL write on the same edge: the CTRL write wins.
  - A LOAD write and a tick on the same edge: the LOAD write wins. COUNT takes the new value and no expiry occurs that cycle.
- EN = 0 freezes COUNT and `pcnt`. Register writes still take effect.
- Unselected or setup-only cycles (`Penable` = 0) never modify state.

## Timing
- Reset (async assert):
  - CTRL, LOAD, COUNT, STATUS and `pcnt` all go to 0.
  - `Irq` = 0; `Prdata` = 0 unless a read is in progress.
- Reset mid-operation aborts the count immediately. The timer resumes only after software rewrites CTRL.
- Write latency: the new value is visible on `Prdata` in the cycle after the access-phase edge.
- Counter latency: with PRESC = 0 and EN set by a write at edge N, the first decrement happens at edge N+1.
- Expiry to `Irq`: EXP sets on the expiry edge and `Irq` rises in the same cycle that follows. The `Irq` rise needs IE = 1.
- There are no wait states. Every APB transfer completes in exactly 2 cycles (setup + access), as issued by the bridge.

## Test plan
- **Reset:** assert `Hreset` mid-count → all registers read 0 and `Irq` = 0 immediately after reset releases; COUNT does not move.
- **One-shot:**
  - Stimulus: LOAD = 3, then CTRL = 0x0000_0005 (EN = 1, IE = 1, PRESC = 0).
  - Required: COUNT reads 3, 2, 1, 0 on successive cycles. On the next tick EXP = 1, `Irq` = 1 and CTRL.EN reads 0.
- **Auto-reload with prescale:**
  - Stimulus: LOAD = 2, CTRL = 0x0000_0103 (PRESC = 1, AUTO = 1, EN = 1).
  - Required: EXP sets every 6 cycles and COUNT cycles through 2, 1, 0, 2, ...
- **W1C and collision:**
  - Writing STATUS = 1 clears EXP and drops `Irq`.
  - Issuing the W1C on the same edge as an expiry leaves EXP = 1.
- **Decode:**
  - Pselx selecting another slave, writing LOAD = 0xDEAD → LOAD unchanged.
  - Write to offset 0x10 → ignored, and a read of 0x10 returns 0.
  - Write to COUNT → ignored.
- **Read path:** a read of LOAD = 0x1234 returns 0x1234 on `Prdata` in both setup and access cycles. `Prdata` returns to 0 once `sel` deasserts.
